// File: rtl/sudoku_board_loader_if.sv
// Digit stream from the handwritten-digit recogniser into the board loader.
// Row-major valid/ready handshake, one 4-bit digit per transfer.
interface sudoku_board_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_digit;

    modport master (
        output in_valid,
        output in_digit,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_digit,
        output in_ready
    );
endinterface

// File: rtl/sudoku_board_loader.sv
// Collects 81 recognised digits into packed board vectors for the solver.
// Pulses start once the board is complete, then holds it until the next capture.
module sudoku_board_loader #(
    parameter int          CELLS   = 81,
    parameter logic [31:0] TIMEOUT = 32'd50000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   capture,
    input  logic                   abort,
    sudoku_board_loader_if.slave   in_if,
    output logic [4*CELLS-1:0]     init_board,
    output logic [CELLS-1:0]       init_board_blank,
    output logic                   start,
    output logic                   busy,
    output logic [6:0]             cell_idx,
    output logic                   err,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [4*CELLS-1:0]   board_nxt;
    logic [CELLS-1:0]     blank_nxt;
    logic [6:0]           idx_nxt;
    logic                 err_nxt;
    logic                 tmo_nxt;
    logic [31:0]          idle_cnt;
    logic [31:0]          idle_nxt;
    logic                 hs;
    logic [8:0]           nib_base;
    logic [3:0]           digit;

    assign in_if.in_ready = (state == LOAD);
    assign hs             = in_if.in_valid & in_if.in_ready;
    assign digit          = in_if.in_digit;
    assign nib_base       = {cell_idx, 2'b00};

    always_comb begin
        state_nxt = state;
        board_nxt = init_board;
        blank_nxt = init_board_blank;
        idx_nxt   = cell_idx;
        err_nxt   = err;
        tmo_nxt   = timeout;
        idle_nxt  = idle_cnt;
        unique case (state)
            IDLE, HOLD: begin
                if (capture && !abort) begin
                    state_nxt = LOAD;
                    board_nxt = '0;
                    blank_nxt = '0;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                    tmo_nxt   = 1'b0;
                    idle_nxt  = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                    board_nxt = '0;
                    blank_nxt = '0;
                    idx_nxt   = '0;
                    idle_nxt  = '0;
                end else if (hs) begin
                    idle_nxt = '0;
                    // out-of-range digits become editable blanks and flag err
                    if (digit >= 4'd1 && digit <= 4'd9) begin
                        board_nxt[nib_base +: 4] = digit;
                        blank_nxt[cell_idx]      = 1'b0;
                    end else begin
                        board_nxt[nib_base +: 4] = 4'd0;
                        blank_nxt[cell_idx]      = 1'b1;
                        if (digit > 4'd9) begin
                            err_nxt = 1'b1;
                        end
                    end
                    if (cell_idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = cell_idx + 7'd1;
                    end
                end else if (idle_cnt == TIMEOUT - 32'd1) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 1'b1;
                    board_nxt = '0;
                    blank_nxt = '0;
                    idx_nxt   = '0;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + 32'd1;
                end
            end
            DONE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    board_nxt = '0;
                    blank_nxt = '0;
                    idx_nxt   = '0;
                    idle_nxt  = '0;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            init_board       <= '0;
            init_board_blank <= '0;
            start            <= 1'b0;
            busy             <= 1'b0;
            cell_idx         <= '0;
            err              <= 1'b0;
            timeout          <= 1'b0;
            idle_cnt         <= '0;
        end else begin
            state            <= state_nxt;
            init_board       <= board_nxt;
            init_board_blank <= blank_nxt;
            start            <= (state_nxt == DONE);
            busy             <= (state_nxt == LOAD) || (state_nxt == DONE);
            cell_idx         <= idx_nxt;
            err              <= err_nxt;
            timeout          <= tmo_nxt;
            idle_cnt         <= idle_nxt;
        end
    end

endmodule

// File: tb/tb_sudoku_board_loader.sv
// Directed bench for sudoku_board_loader: full loads, blanks, bad digits,
// timeout, abort, async reset and the HOLD phase.
module tb_sudoku_board_loader;

    logic         clk;
    logic         reset_n;
    logic         capture;
    logic         abort;
    logic [323:0] init_board;
    logic [80:0]  init_board_blank;
    logic         start;
    logic         busy;
    logic [6:0]   cell_idx;
    logic         err;
    logic         timeout;

    int n_checks;
    int n_errors;

    logic [3:0]   digs [81];
    logic [323:0] exp_board;
    logic [80:0]  exp_blank;
    logic         exp_err;
    logic [323:0] saved;
    int           early;

    sudoku_board_loader_if bus();

    sudoku_board_loader #(
        .CELLS   (81),
        .TIMEOUT (32'd16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .capture          (capture),
        .abort            (abort),
        .in_if            (bus),
        .init_board       (init_board),
        .init_board_blank (init_board_blank),
        .start            (start),
        .busy             (busy),
        .cell_idx         (cell_idx),
        .err              (err),
        .timeout          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [323:0] got,
                       input logic [323:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp();
        exp_board = '0;
        exp_blank = '0;
        exp_err   = 1'b0;
        for (int i = 0; i < 81; i++) begin
            if (digs[i] >= 4'd1 && digs[i] <= 4'd9) begin
                exp_board[4*i +: 4] = digs[i];
            end else begin
                exp_blank[i] = 1'b1;
                if (digs[i] > 4'd9) exp_err = 1'b1;
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 81; i++) digs[i] = 4'((i % 9) + 1);
    endtask

    task automatic do_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    // drives n cells with in_valid held high; counts any start before the end
    task automatic stream(input int n);
        early = 0;
        for (int i = 0; i < n; i++) begin
            bus.in_digit = digs[i];
            bus.in_valid = 1'b1;
            tick();
            if (start && i < 80) early++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic full_load(input string tag);
        build_exp();
        do_capture();
        chk({tag, "_err_clr"}, 324'(err), 324'd0);
        stream(81);
        chk({tag, "_no_early"}, 324'(early), 324'd0);
        chk({tag, "_start"}, 324'(start), 324'd1);
        chk({tag, "_rdy_done"}, 324'(bus.in_ready), 324'd0);
        tick();
        chk({tag, "_start_1cy"}, 324'(start), 324'd0);
        chk({tag, "_board"}, init_board, exp_board);
        chk({tag, "_blank"}, 324'(init_board_blank), 324'(exp_blank));
        chk({tag, "_errf"}, 324'(err), 324'(exp_err));
        chk({tag, "_idx"}, 324'(cell_idx), 324'd80);
        chk({tag, "_busy"}, 324'(busy), 324'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        capture      = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_digit = 4'd0;
        #23;
        chk("rst_board", init_board, 324'd0);
        chk("rst_rdy", 324'(bus.in_ready), 324'd0);
        chk("rst_busy", 324'(busy), 324'd0);
        reset_n = 1'b1;
        tick();

        // 1: ramp board
        fill_ramp();
        full_load("t1");
        chk("t1_nib0", 324'(init_board[3:0]), 324'd1);
        chk("t1_nib80", 324'(init_board[323:320]), 324'd9);
        chk("t1_blank0", 324'(init_board_blank), 324'd0);

        // 2: blanks at 0, 40, 80
        fill_ramp();
        digs[0]  = 4'd0;
        digs[40] = 4'd0;
        digs[80] = 4'd0;
        full_load("t2");
        chk("t2_blank", 324'(init_board_blank),
            324'({1'b1, 39'b0, 1'b1, 39'b0, 1'b1}));
        chk("t2_nib40", 324'(init_board[163:160]), 324'd0);

        // 3: bad digit at cell 5
        fill_ramp();
        digs[5] = 4'hC;
        full_load("t3");
        chk("t3_err", 324'(err), 324'd1);
        chk("t3_blank5", 324'(init_board_blank[5]), 324'd1);
        chk("t3_nib5", 324'(init_board[23:20]), 324'd0);

        // 4: timeout after 10 cells
        fill_ramp();
        do_capture();
        chk("t4_err_clr", 324'(err), 324'd0);
        stream(10);
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (start) early++;
            if (k == 15) begin
                chk("t4_tmo_15", 324'(timeout), 324'd0);
                chk("t4_busy_15", 324'(busy), 324'd1);
            end
        end
        chk("t4_tmo", 324'(timeout), 324'd1);
        chk("t4_busy", 324'(busy), 324'd0);
        chk("t4_rdy", 324'(bus.in_ready), 324'd0);
        chk("t4_board", init_board, 324'd0);
        chk("t4_blank", 324'(init_board_blank), 324'd0);
        chk("t4_nostart", 324'(early), 324'd0);

        // 5a: abort together with the 81st handshake
        do_capture();
        chk("t5_tmo_clr", 324'(timeout), 324'd0);
        stream(80);
        bus.in_digit = 4'd9;
        bus.in_valid = 1'b1;
        abort        = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        abort        = 1'b0;
        chk("t5_start", 324'(start), 324'd0);
        chk("t5_busy", 324'(busy), 324'd0);
        chk("t5_board", init_board, 324'd0);
        chk("t5_blank", 324'(init_board_blank), 324'd0);
        tick();
        chk("t5_start2", 324'(start), 324'd0);

        // 5b: async reset after cell 30
        do_capture();
        stream(30);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5r_board", init_board, 324'd0);
        chk("t5r_blank", 324'(init_board_blank), 324'd0);
        chk("t5r_idx", 324'(cell_idx), 324'd0);
        chk("t5r_busy", 324'(busy), 324'd0);
        chk("t5r_rdy", 324'(bus.in_ready), 324'd0);
        chk("t5r_start", 324'(start), 324'd0);
        #10;
        reset_n = 1'b1;
        tick();

        // 6: HOLD ignores the stream, capture clears
        fill_ramp();
        digs[17] = 4'd0;
        full_load("t6");
        saved = init_board;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_digit = 4'($urandom_range(0, 15));
            tick();
            chk("t6_rdy", 324'(bus.in_ready), 324'd0);
            chk("t6_hold", init_board, exp_board);
        end
        bus.in_valid = 1'b0;
        chk("t6_saved", saved, exp_board);
        do_capture();
        chk("t6_clr_board", init_board, 324'd0);
        chk("t6_clr_idx", 324'(cell_idx), 324'd0);
        chk("t6_clr_busy", 324'(busy), 324'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
